pc_sequencer: RTL

- Multicycle instruction sequencer for the CPU core.
- Owns the program_counter update handshake: drives pcNext/pcWrite and orders fetch, decode, execute, memory and writeback.
- Computes the next PC for sequential, branch, jal and jalr flow, with memory-wait handshakes.
- Redirects to a trap vector on a misaligned target or a bus timeout, and counts retired instructions.

---
 rtl/cpu_pkg.sv | 21 ++
 rtl/seq_next_pc.sv | 36 +++
 rtl/pc_sequencer.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared types and constants for the multicycle sequencer: FSM state
// encoding, trap cause codes and the sequential PC increment.
package cpu_pkg;

   typedef enum logic [2:0] {
      ST_FETCH  = 3'd0,
      ST_DECODE = 3'd1,
      ST_EXEC   = 3'd2,
      ST_MEM    = 3'd3,
      ST_WB     = 3'd4,
      ST_TRAP   = 3'd5
   } seq_state_t;

   localparam logic [1:0] CAUSE_NONE     = 2'b00;
   localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
   localparam logic [1:0] CAUSE_FETCH_TO = 2'b10;
   localparam logic [1:0] CAUSE_DATA_TO  = 2'b11;

   localparam logic [31:0] PC_INC = 32'd4;

endpackage

// File: rtl/seq_next_pc.sv
// Combinational next-PC unit: picks jal > jalr > taken branch > sequential
// and flags a target that is not word aligned.
module seq_next_pc
   import cpu_pkg::*;
(
   input  logic [31:0] pc,
   input  logic [31:0] imm,
   input  logic [31:0] rs1_val,
   input  logic        is_branch,
   input  logic        is_jal,
   input  logic        is_jalr,
   input  logic        br_taken,
   output logic [31:0] target,
   output logic        misaligned
);

   logic [31:0] w_pc_rel;
   logic [31:0] w_reg_rel;

   assign w_pc_rel  = pc + imm;
   assign w_reg_rel = (rs1_val + imm) & ~32'h1;

   always_comb begin
      target = pc + PC_INC;
      if (is_jal) begin
         target = w_pc_rel;
      end else if (is_jalr) begin
         target = w_reg_rel;
      end else if (is_branch && br_taken) begin
         target = w_pc_rel;
      end
   end

   assign misaligned = (target[1:0] != 2'b00);

endmodule

// File: rtl/pc_sequencer.sv
// Multicycle instruction sequencer: orders fetch/decode/execute/memory/
// writeback, drives the PC update handshake, traps and counts retirements.
//
//   state  | meaning
//   -------+-------------------------------------------------------------
//   FETCH  | imem_req high, wait for imem_ack (bounded by TIMEOUT)
//   DECODE | one cycle for decoder flags to settle
//   EXEC   | register next PC or trap vector on misaligned target
//   MEM    | dmem_req high, wait for dmem_ack (bounded by TIMEOUT)
//   WB     | pc_write strobe, optional reg_write, instret += 1
//   TRAP   | pc_write + trap strobe with pc_next = TRAP_VEC
module pc_sequencer
   import cpu_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] TRAP_VEC = 32'h0000_0100,
   parameter int          TIMEOUT  = 16
) (
   input  logic        CLK,
   input  logic        RES,
   input  logic [31:0] pc,
   output logic        imem_req,
   input  logic        imem_ack,
   output logic        ir_write,
   input  logic        is_branch,
   input  logic        is_jal,
   input  logic        is_jalr,
   input  logic        is_load,
   input  logic        is_store,
   input  logic        br_taken,
   input  logic [31:0] imm,
   input  logic [31:0] rs1_val,
   output logic        dmem_req,
   input  logic        dmem_ack,
   output logic        reg_write,
   output logic [31:0] pc_next,
   output logic        pc_write,
   output logic        trap,
   output logic [1:0]  trap_cause,
   output logic [31:0] instret
);

   localparam logic        TO_EN   = (TIMEOUT > 0);
   localparam logic [31:0] TO_LAST = (TIMEOUT > 0) ? 32'(TIMEOUT - 1) : 32'd0;

   seq_state_t  r_state;
   seq_state_t  w_state_next;
   logic [31:0] r_pc_next;
   logic [1:0]  r_cause;
   logic [31:0] r_instret;
   logic [31:0] r_wait;

   logic [31:0] w_target;
   logic        w_misaligned;
   logic        w_timeout;
   logic        w_wait_inc;
   logic [1:0]  w_cause;
   logic        w_rw_ok;

   seq_next_pc u_next_pc (
      .pc         (pc),
      .imm        (imm),
      .rs1_val    (rs1_val),
      .is_branch  (is_branch),
      .is_jal     (is_jal),
      .is_jalr    (is_jalr),
      .br_taken   (br_taken),
      .target     (w_target),
      .misaligned (w_misaligned)
   );

   assign w_timeout = TO_EN && (r_wait == TO_LAST);

   always_ff @(posedge CLK or negedge RES) begin
      if (!RES) begin
         r_state <= ST_FETCH;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_wait_inc   = 1'b0;
      w_cause      = CAUSE_NONE;
      case (r_state)
         ST_FETCH: begin
            if (imem_ack) begin
               w_state_next = ST_DECODE;
            end else if (w_timeout) begin
               w_state_next = ST_TRAP;
               w_cause      = CAUSE_FETCH_TO;
            end else begin
               w_wait_inc = 1'b1;
            end
         end
         ST_DECODE: w_state_next = ST_EXEC;
         ST_EXEC: begin
            if (w_misaligned) begin
               w_state_next = ST_TRAP;
               w_cause      = CAUSE_MISALIGN;
            end else if (is_load || is_store) begin
               w_state_next = ST_MEM;
            end else begin
               w_state_next = ST_WB;
            end
         end
         ST_MEM: begin
            if (dmem_ack) begin
               w_state_next = ST_WB;
            end else if (w_timeout) begin
               w_state_next = ST_TRAP;
               w_cause      = CAUSE_DATA_TO;
            end else begin
               w_wait_inc = 1'b1;
            end
         end
         ST_WB:   w_state_next = ST_FETCH;
         ST_TRAP: w_state_next = ST_FETCH;
         default: w_state_next = ST_FETCH;
      endcase
   end

   always_ff @(posedge CLK or negedge RES) begin
      if (!RES) begin
         r_pc_next <= RESET_PC;
         r_cause   <= CAUSE_NONE;
         r_instret <= 32'd0;
         r_wait    <= 32'd0;
      end else begin
         if (r_state == ST_EXEC) begin
            r_pc_next <= w_misaligned ? TRAP_VEC : w_target;
         end
         if ((w_state_next == ST_TRAP) && (r_state != ST_TRAP)) begin
            r_pc_next <= TRAP_VEC;
            r_cause   <= w_cause;
         end
         if (w_state_next != r_state) begin
            r_wait <= 32'd0;
         end else if (w_wait_inc) begin
            r_wait <= r_wait + 32'd1;
         end
         if (r_state == ST_WB) begin
            r_instret <= r_instret + 32'd1;
         end
      end
   end

   // A load+store combination behaves as a load, so it still writes back.
   assign w_rw_ok = !(is_store && !is_load) && !(is_branch && !is_jal && !is_jalr);

   // Gated by RES so nothing is requested while reset holds the FSM in FETCH.
   assign imem_req   = RES && (r_state == ST_FETCH);
   assign ir_write   = imem_req && imem_ack;
   assign dmem_req   = RES && (r_state == ST_MEM);
   assign pc_write   = RES && ((r_state == ST_WB) || (r_state == ST_TRAP));
   assign trap       = RES && (r_state == ST_TRAP);
   assign reg_write  = RES && (r_state == ST_WB) && w_rw_ok;
   assign pc_next    = r_pc_next;
   assign trap_cause = r_cause;
   assign instret    = r_instret;

endmodule
